// File: rtl/encdec_mul_arbiter.sv
// ---------------------------------------------------------------------------
// encdec_mul_arbiter
//
// One pipelined unsigned multiplier is shared by NUM_REQ requesters. A
// round-robin arbiter accepts at most one operand pair per cycle and pushes it
// into a MUL_STAGES-deep pipeline. Products return in accept order on a single
// tagged response bus that has valid/ready backpressure.
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]         per-requester operand valid
//   req_ready  out  [NUM_REQ]         per-requester grant, one-hot or zero
//   req_a      in   [NUM_REQ*DATA_W]  packed operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b      in   [NUM_REQ*DATA_W]  packed operand B, same packing
//   rsp_valid  out                    response valid (output register)
//   rsp_ready  in                     downstream accepts the response
//   rsp_id     out  [ID_W]            index of the requester that issued the product
//   rsp_p      out  [2*DATA_W]        full unsigned product a*b
//   busy       out                    any pipeline stage holds a valid entry
// ---------------------------------------------------------------------------
module encdec_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 16,
  parameter int MUL_STAGES = 2,
  parameter int ID_W       = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*DATA_W-1:0]       rsp_p,
  output logic                      busy
);

  localparam int P_W  = 2 * DATA_W;
  localparam int LAST = MUL_STAGES - 1;

  // Full-width unsigned product; operands are widened first so nothing is lost.
  function automatic logic [P_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

  // Round-robin search starting just after ptr. Returns {found, index}.
  function automatic logic [ID_W:0] rr_search(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        found = 1'b1;
        id    = idx;
      end else begin
        found = found;
      end
    end
    return {found, id};
  endfunction

  // Stage 0 holds {a, b} when MUL_STAGES > 1 (the multiply happens on the way
  // into stage 1), or the finished product when MUL_STAGES == 1. Every later
  // stage holds a product; the last stage is the output register.
  logic [MUL_STAGES-1:0] valid_q, valid_d;
  logic [ID_W-1:0]       id_q   [MUL_STAGES];
  logic [ID_W-1:0]       id_d   [MUL_STAGES];
  logic [P_W-1:0]        data_q [MUL_STAGES];
  logic [P_W-1:0]        data_d [MUL_STAGES];
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic                  stall_s;
  logic [ID_W:0]         search_s;
  logic                  grant_found_s;
  logic [ID_W-1:0]       grant_id_s;
  logic                  xfer_s;
  logic [DATA_W-1:0]     sel_a_s;
  logic [DATA_W-1:0]     sel_b_s;

  assign stall_s       = valid_q[LAST] & ~rsp_ready;
  assign search_s      = rr_search(req_valid, rr_ptr_q);
  assign grant_found_s = search_s[ID_W];
  assign grant_id_s    = search_s[ID_W-1:0];
  assign sel_a_s       = req_a[grant_id_s*DATA_W +: DATA_W];
  assign sel_b_s       = req_b[grant_id_s*DATA_W +: DATA_W];
  assign xfer_s        = |(req_valid & req_ready);

  // Grant decode: the winning requester is told ready unless the pipe is stalled.
  always_comb begin
    req_ready = '0;
    if (grant_found_s && !stall_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next state of the arbiter pointer and every pipeline stage; all stages
  // advance together, so a stall freezes the whole pipe.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    for (int j = 0; j < MUL_STAGES; j++) begin
      id_d[j]   = id_q[j];
      data_d[j] = data_q[j];
    end
    if (!stall_s) begin
      valid_d[0] = xfer_s;
      if (xfer_s) begin
        rr_ptr_d = grant_id_s;
        id_d[0]  = grant_id_s;
        if (MUL_STAGES == 1) begin
          data_d[0] = mul_full(sel_a_s, sel_b_s);
        end else begin
          data_d[0] = {sel_a_s, sel_b_s};
        end
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
      for (int j = 1; j < MUL_STAGES; j++) begin
        valid_d[j] = valid_q[j-1];
        id_d[j]    = id_q[j-1];
        if (j == 1) begin
          data_d[j] = mul_full(data_q[0][P_W-1:DATA_W], data_q[0][DATA_W-1:0]);
        end else begin
          data_d[j] = data_q[j-1];
        end
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers; reset drops every in-flight entry and gives requester 0
  // first priority.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      valid_q  <= '0;
      for (int j = 0; j < MUL_STAGES; j++) begin
        id_q[j]   <= '0;
        data_q[j] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      for (int j = 0; j < MUL_STAGES; j++) begin
        id_q[j]   <= id_d[j];
        data_q[j] <= data_d[j];
      end
    end
  end

  assign rsp_valid = valid_q[LAST];
  assign rsp_id    = id_q[LAST];
  assign rsp_p     = data_q[LAST];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_encdec_mul_arbiter.sv
// Directed bench for encdec_mul_arbiter (NUM_REQ=4, DATA_W=16, MUL_STAGES=2).
module tb_encdec_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 16;
  localparam int MUL_STAGES = 2;
  localparam int ID_W       = 2;

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_p;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Operand table with hand-computed products.
  logic [15:0] tbl_a [4];
  logic [15:0] tbl_b [4];
  logic [31:0] tbl_p [4];

  encdec_mul_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MUL_STAGES(MUL_STAGES),
    .ID_W      (ID_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_p    (rsp_p),
    .busy     (busy)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = tbl_a[i];
      req_b[i*16 +: 16] = tbl_b[i];
    end
  endtask

  logic [3:0] exp_g [5];

  initial begin
    tbl_a[0] = 16'h0002; tbl_b[0] = 16'h0007; tbl_p[0] = 32'h0000_000E;
    tbl_a[1] = 16'h0010; tbl_b[1] = 16'h0009; tbl_p[1] = 32'h0000_0090;
    tbl_a[2] = 16'h0100; tbl_b[2] = 16'h000B; tbl_p[2] = 32'h0000_0B00;
    tbl_a[3] = 16'h1000; tbl_b[3] = 16'h000D; tbl_p[3] = 32'h0000_D000;

    ap_rst    = 1'b1;
    req_valid = 4'b0000;
    req_a     = 64'h0;
    req_b     = 64'h0;
    rsp_ready = 1'b1;

    // ---- reset state
    step();
    step();
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_id",    {30'b0, rsp_id},    32'h0);
    check_eq("rst_rsp_p",     rsp_p,              32'h0);
    check_eq("rst_busy",      {31'b0, busy},      32'h0);
    ap_rst = 1'b0;

    // ---- single request from requester 0: 3*5
    req_a[15:0] = 16'h0003;
    req_b[15:0] = 16'h0005;
    req_valid   = 4'b0001;
    #1;
    check_eq("t1_ready", {28'b0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t1_lat_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("t1_lat_busy",  {31'b0, busy},      32'h1);
    step();
    check_eq("t1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("t1_rsp_id",    {30'b0, rsp_id},    32'h0);
    check_eq("t1_rsp_p",     rsp_p,              32'h0000_000F);
    step();
    check_eq("t1_idle_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("t1_idle_busy",  {31'b0, busy},      32'h0);

    // ---- requester 3, max operands (pointer is 0, search 1,2,3)
    req_a[63:48] = 16'hFFFF;
    req_b[63:48] = 16'hFFFF;
    req_valid    = 4'b1000;
    #1;
    check_eq("t3_ready", {28'b0, req_ready}, 32'h8);
    step();
    req_valid = 4'b0000;
    step();
    check_eq("t3_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("t3_rsp_id",    {30'b0, rsp_id},    32'h3);
    check_eq("t3_rsp_p",     rsp_p,              32'hFFFE_0001);
    step();

    // ---- all four valid: grants 0,1,2,3,0,1,2,3 and back-to-back responses
    load_table();
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = 4'b0000;
      #1;
      if (c < 8) check_eq($sformatf("t2_grant%0d", c), {28'b0, req_ready}, 32'h1 << (c % 4));
      else       check_eq($sformatf("t2_grant%0d", c), {28'b0, req_ready}, 32'h0);
      if (c >= 2) begin
        check_eq($sformatf("t2_valid%0d", c), {31'b0, rsp_valid}, 32'h1);
        check_eq($sformatf("t2_id%0d", c),    {30'b0, rsp_id},    32'((c - 2) % 4));
        check_eq($sformatf("t2_p%0d", c),     rsp_p,              tbl_p[(c - 2) % 4]);
      end
      step();
    end
    check_eq("t2_end_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("t2_end_busy",  {31'b0, busy},      32'h0);

    // ---- backpressure: requesters 1 and 2, output stalled for 5 cycles
    req_valid = 4'b0110;
    #1;
    check_eq("t4_grant_a", {28'b0, req_ready}, 32'h2);
    step();
    check_eq("t4_grant_b", {28'b0, req_ready}, 32'h4);
    step();
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("t4_stall_ready%0d", c), {28'b0, req_ready}, 32'h0);
      check_eq($sformatf("t4_stall_valid%0d", c), {31'b0, rsp_valid}, 32'h1);
      check_eq($sformatf("t4_stall_id%0d", c),    {30'b0, rsp_id},    32'h1);
      check_eq($sformatf("t4_stall_p%0d", c),     rsp_p,              tbl_p[1]);
      check_eq($sformatf("t4_stall_busy%0d", c),  {31'b0, busy},      32'h1);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1;
    check_eq("t4_rel_id", {30'b0, rsp_id}, 32'h1);
    step();
    check_eq("t4_drain_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("t4_drain_id",    {30'b0, rsp_id},    32'h2);
    check_eq("t4_drain_p",     rsp_p,              tbl_p[2]);
    step();
    check_eq("t4_end_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("t4_end_busy",  {31'b0, busy},      32'h0);

    // ---- wrap-around and skipping: requesters 0 and 2, last grant was to 2
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001;
    exp_g[3] = 4'b0000; exp_g[4] = 4'b0000;
    req_valid = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) req_valid = 4'b0000;
      #1;
      check_eq($sformatf("t5_grant%0d", c), {28'b0, req_ready}, {28'b0, exp_g[c]});
      if (c >= 2) begin
        check_eq($sformatf("t5_valid%0d", c), {31'b0, rsp_valid}, 32'h1);
        check_eq($sformatf("t5_id%0d", c),    {30'b0, rsp_id},    (c == 3) ? 32'h2 : 32'h0);
        check_eq($sformatf("t5_p%0d", c),     rsp_p,              (c == 3) ? tbl_p[2] : tbl_p[0]);
      end
      step();
    end
    check_eq("t5_end_valid", {31'b0, rsp_valid}, 32'h0);

    // ---- asynchronous reset with two products in flight
    req_valid = 4'b1111;
    step();
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t6_pre_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("t6_pre_id",    {30'b0, rsp_id},    32'h1);
    #1;
    ap_rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("t6_rst_busy",  {31'b0, busy},      32'h0);
    check_eq("t6_rst_p",     rsp_p,              32'h0);
    step();
    ap_rst    = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_eq("t6_first_grant", {28'b0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t6_no_replay", {31'b0, rsp_valid}, 32'h0);
    step();
    check_eq("t6_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("t6_rsp_id",    {30'b0, rsp_id},    32'h0);
    check_eq("t6_rsp_p",     rsp_p,              tbl_p[0]);
    step();
    check_eq("t6_end_busy", {31'b0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encdec_mul_arbiter.md
Name: encdec_mul_arbiter

Overview:
- Shares one pipelined 16x16 unsigned multiplier between NUM_REQ independent requesters in the encdec datapath.
- Round-robin arbitration selects one operand pair per cycle and pushes it into a MUL_STAGES-deep product pipeline.
- Results return on a single tagged response bus with valid/ready backpressure.
- Replaces per-requester multiplier instances where throughput allows, saving DSP48 slices.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 16, operand width; product width is 2*DATA_W.
- MUL_STAGES, 2, total register stages from accept to rsp_valid, including the output register; legal minimum 1.
- ID_W, 2, tag width; must equal ceil(log2(NUM_REQ)).

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B; same packing as req_a.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  ID_W  index of the requester that issued this product.
- rsp_p  out  2*DATA_W  unsigned product a*b.
- busy  out  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, all stage valid bits=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority after reset).
- Reset asserted mid-operation drops all in-flight products; none are replayed.
- Stall condition: stall = rsp_valid & ~rsp_ready.
  - While stalled, every pipeline stage holds its contents and req_ready=0.
- Arbitration is combinational from req_valid, rr_ptr and stall.
  - Search order: rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_REQ.
  - The first requester in that order with req_valid=1 gets req_ready=1.
  - All other req_ready bits are 0.
  - If no requester is valid, or stall=1, req_ready is all zeros.
- A transfer occurs when req_valid[i] & req_ready[i].
  - On transfer: rr_ptr <= i. Stage 1 captures valid=1, id=i, a and b, or the product if MUL_STAGES=1.
  - With no transfer and no stall: rr_ptr holds and stage 1 captures valid=0.
- Requesters may drop req_valid without a transfer. req_ready may depend combinationally on req_valid, so requesters must not make req_valid depend on req_ready.
- Pipeline timing:
  - The multiply is computed as a full 2*DATA_W unsigned product, never truncated.
  - Each stage advances only when stall=0.
  - With no stall, a transfer at rising edge k gives rsp_valid=1 with matching rsp_id/rsp_p after edge k+MUL_STAGES-1, i.e. visible MUL_STAGES cycles after the accept cycle.
- Output register:
  - When rsp_valid & rsp_ready, the output register loads the next stage in the same edge.
  - Back-to-back transfers give one response per cycle at full throughput.
  - Bubbles propagate as rsp_valid=0.
- Ordering: responses leave strictly in accept order. Tags are the only way to route results.
- busy = OR of all stage valid bits, including the output register.

Test Plan:
- Reset, then only requester 0 valid with a=0x0003, b=0x0005 and rsp_ready=1 -> req_ready=0001 in the accept cycle; after MUL_STAGES=2 cycles rsp_valid=1, rsp_id=0, rsp_p=0x0000000F.
- All four requesters continuously valid, rsp_ready=1 -> grants cycle 0,1,2,3,0,... one per cycle; responses arrive back-to-back with ids 0,1,2,3 in order and each product correct.
- a=b=0xFFFF from requester 3 -> rsp_p=0xFFFE0001, rsp_id=3; no truncation.
- Requesters 1 and 2 valid with rsp_ready held 0 for 5 cycles after the first response -> req_ready=0 and rsp_p/rsp_id stable for all 5 cycles; on release, remaining products drain in order with none lost or duplicated.
- Requesters 0 and 2 valid after last grant to 2 -> next grant goes to 0; after last grant to 0 -> next grant goes to 2 (wrap-around and skipping of idle requesters).
- Assert ap_rst asynchronously mid-stream with two products in flight -> rsp_valid and busy drop immediately without a clock edge; after deassert, the first grant goes to requester 0.
